// File: rtl/soc_end_mon.sv
// End-of-test monitor: detects the terminating ebreak on the commit port, waits a drain window, then raises a sticky verdict.
// Latency: end_data/end_pc registered 1 edge after the ebreak commit; end_flag after DRAIN_CYCLES further edges (same edge if 0).
// Backpressure: none; the commit port is observe-only and is never stalled.
//
// Ports:
//   i_sys_clk, i_sys_rst        clock and synchronous active-high reset
//   i_cmt_valid/inst/pc/a0      retiring-instruction observation port
//   o_end_flag, o_end_data      sticky done flag and verdict (captured a0, or FAIL_CODE on timeout)
//   o_end_pc                    PC of the ebreak, or all-ones on timeout
//   o_cmt_cnt                   saturating retired-instruction count (frozen once RUN is left)
//   o_busy                      high while in RUN or DRAIN (always the inverse of o_end_flag)
module soc_end_mon #(
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           DRAIN_CYCLES   = 4,
    parameter logic [31:0]           TIMEOUT_CYCLES = 32'd100000,
    parameter logic [31:0]           EBREAK_INST    = 32'h0010_0073,
    parameter logic [DATA_WIDTH-1:0] FAIL_CODE      = DATA_WIDTH'(32'h1)
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_cmt_valid,
    input  logic [31:0]           i_cmt_inst,
    input  logic [31:0]           i_cmt_pc,
    input  logic [DATA_WIDTH-1:0] i_cmt_a0,
    output logic                  o_end_flag,
    output logic [DATA_WIDTH-1:0] o_end_data,
    output logic [31:0]           o_end_pc,
    output logic [31:0]           o_cmt_cnt,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [31:0] DRAIN_INIT = 32'(DRAIN_CYCLES);
    localparam logic [31:0] WDOG_LAST  = TIMEOUT_CYCLES - 32'd1;
    localparam bit          WDOG_EN    = (TIMEOUT_CYCLES != 32'd0);
    localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF;
    localparam logic [31:0] TIMEOUT_PC = 32'hFFFF_FFFF;

    state_e                state_q,    state_d;
    logic [31:0]           wdog_q,     wdog_d;
    logic [31:0]           drain_q,    drain_d;
    logic                  end_flag_q, end_flag_d;
    logic [DATA_WIDTH-1:0] end_data_q, end_data_d;
    logic [31:0]           end_pc_q,   end_pc_d;
    logic [31:0]           cmt_cnt_q,  cmt_cnt_d;
    logic                  busy_q,     busy_d;

    logic is_ebreak;
    logic wdog_hit;

    assign is_ebreak = i_cmt_valid && (i_cmt_inst == EBREAK_INST);
    // Timeout fires on the last watchdog value, so the counter never has to wrap.
    assign wdog_hit  = WDOG_EN && (wdog_q == WDOG_LAST);

    always_comb begin
        state_d    = state_q;
        wdog_d     = wdog_q;
        drain_d    = drain_q;
        end_data_d = end_data_q;
        end_pc_d   = end_pc_q;
        cmt_cnt_d  = cmt_cnt_q;

        unique case (state_q)
            ST_RUN: begin
                if (i_cmt_valid && (cmt_cnt_q != CNT_MAX)) begin
                    cmt_cnt_d = cmt_cnt_q + 32'd1;
                end
                // Saturate so a disabled watchdog can sit here forever harmlessly.
                if (wdog_q != CNT_MAX) begin
                    wdog_d = wdog_q + 32'd1;
                end
                // Ebreak has priority over a simultaneous watchdog expiry.
                if (is_ebreak) begin
                    end_data_d = i_cmt_a0;
                    end_pc_d   = i_cmt_pc;
                    drain_d    = DRAIN_INIT;
                    state_d    = (DRAIN_INIT == 32'd0) ? ST_DONE : ST_DRAIN;
                end else if (wdog_hit) begin
                    end_data_d = FAIL_CODE;
                    end_pc_d   = TIMEOUT_PC;
                    state_d    = ST_DONE;
                end
            end
            ST_DRAIN: begin
                // Commits are ignored here; only the drain countdown advances.
                if (drain_q != 32'd0) begin
                    drain_d = drain_q - 32'd1;
                end
                if (drain_q <= 32'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Flag and busy are derived from the next state so they register on
        // the same edge that the state changes.
        end_flag_d = (state_d == ST_DONE);
        busy_d     = !end_flag_d;
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q    <= ST_RUN;
            wdog_q     <= 32'd0;
            drain_q    <= 32'd0;
            end_flag_q <= 1'b0;
            end_data_q <= '0;
            end_pc_q   <= 32'd0;
            cmt_cnt_q  <= 32'd0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            wdog_q     <= wdog_d;
            drain_q    <= drain_d;
            end_flag_q <= end_flag_d;
            end_data_q <= end_data_d;
            end_pc_q   <= end_pc_d;
            cmt_cnt_q  <= cmt_cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign o_end_flag = end_flag_q;
    assign o_end_data = end_data_q;
    assign o_end_pc   = end_pc_q;
    assign o_cmt_cnt  = cmt_cnt_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_soc_end_mon.sv
// Directed bench for soc_end_mon: three instances share the commit port.
// dut_a: 4-cycle drain, watchdog off; dut_b: zero drain; dut_c: 4-cycle drain, 20-cycle watchdog.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_soc_end_mon;

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        cmt_valid;
    logic [31:0] cmt_inst;
    logic [31:0] cmt_pc;
    logic [31:0] cmt_a0;

    logic        a_flag, b_flag, c_flag;
    logic [31:0] a_data, b_data, c_data;
    logic [31:0] a_pc,   b_pc,   c_pc;
    logic [31:0] a_cnt,  b_cnt,  c_cnt;
    logic        a_busy, b_busy, c_busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    soc_end_mon #(.DRAIN_CYCLES(4), .TIMEOUT_CYCLES(32'd0)) dut_a (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_cmt_valid(cmt_valid), .i_cmt_inst(cmt_inst),
        .i_cmt_pc(cmt_pc), .i_cmt_a0(cmt_a0), .o_end_flag(a_flag), .o_end_data(a_data),
        .o_end_pc(a_pc), .o_cmt_cnt(a_cnt), .o_busy(a_busy)
    );

    soc_end_mon #(.DRAIN_CYCLES(0)) dut_b (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_cmt_valid(cmt_valid), .i_cmt_inst(cmt_inst),
        .i_cmt_pc(cmt_pc), .i_cmt_a0(cmt_a0), .o_end_flag(b_flag), .o_end_data(b_data),
        .o_end_pc(b_pc), .o_cmt_cnt(b_cnt), .o_busy(b_busy)
    );

    soc_end_mon #(.DRAIN_CYCLES(4), .TIMEOUT_CYCLES(32'd20)) dut_c (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_cmt_valid(cmt_valid), .i_cmt_inst(cmt_inst),
        .i_cmt_pc(cmt_pc), .i_cmt_a0(cmt_a0), .o_end_flag(c_flag), .o_end_data(c_data),
        .o_end_pc(c_pc), .o_cmt_cnt(c_cnt), .o_busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cmt_valid = 1'b0;
        cmt_inst  = NOP;
    endtask

    task automatic commit(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] a0);
        cmt_valid = 1'b1;
        cmt_inst  = inst;
        cmt_pc    = pc;
        cmt_a0    = a0;
        step();
        idle();
    endtask

    // Leaves the bench just after the reset edge with reset released, so the
    // next rising edge is the first one that samples watchdog == 0.
    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        cmt_pc = 32'd0;
        cmt_a0 = 32'd0;
        rst = 1'b1;
        step();
        chk_cnt++; if (a_flag !== 1'b0)   $display("FAIL reset_flag: got %0b want 0", a_flag); else pass_cnt++;
        chk_cnt++; if (a_data !== 32'd0)  $display("FAIL reset_data: got %h want 0", a_data); else pass_cnt++;
        chk_cnt++; if (a_pc !== 32'd0)    $display("FAIL reset_pc: got %h want 0", a_pc); else pass_cnt++;
        chk_cnt++; if (a_cnt !== 32'd0)   $display("FAIL reset_cnt: got %0d want 0", a_cnt); else pass_cnt++;
        chk_cnt++; if (a_busy !== 1'b1)   $display("FAIL reset_busy: got %0b want 1", a_busy); else pass_cnt++;
        chk_cnt++; if (c_busy !== 1'b1)   $display("FAIL reset_busy_c: got %0b want 1", c_busy); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_ebreak_drain();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            commit(NOP, 32'h8000_0000 + 32'(i * 4), 32'hA0 + 32'(i));
        end
        chk_cnt++; if (a_cnt !== 32'd5) $display("FAIL run_cnt: got %0d want 5", a_cnt); else pass_cnt++;
        commit(EBREAK, 32'h8000_0018, 32'd0);
        chk_cnt++; if (a_pc !== 32'h8000_0018) $display("FAIL eb_pc: got %h want 80000018", a_pc); else pass_cnt++;
        chk_cnt++; if (a_data !== 32'd0) $display("FAIL eb_data: got %h want 0", a_data); else pass_cnt++;
        chk_cnt++; if (a_cnt !== 32'd6) $display("FAIL eb_cnt: got %0d want 6", a_cnt); else pass_cnt++;
        chk_cnt++; if (a_flag !== 1'b0) $display("FAIL eb_flag_early: got %0b want 0", a_flag); else pass_cnt++;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_cnt++;
            if (a_flag !== (k == 4))
                $display("FAIL drain_flag_edge%0d: got %0b want %0b", k, a_flag, (k == 4));
            else
                pass_cnt++;
        end
        chk_cnt++; if (a_busy !== 1'b0) $display("FAIL done_busy: got %0b want 0", a_busy); else pass_cnt++;
        chk_cnt++; if (a_pc !== 32'h8000_0018) $display("FAIL done_pc: got %h want 80000018", a_pc); else pass_cnt++;
    endtask

    task automatic test_drain_ignore();
        do_reset();
        commit(NOP, 32'h0000_00F8, 32'h11);
        commit(NOP, 32'h0000_00FC, 32'h22);
        commit(EBREAK, 32'h0000_0100, 32'h1234_5678);
        // Four drain cycles: a second ebreak and three normal commits.
        commit(EBREAK, 32'h0000_0200, 32'h1);
        chk_cnt++; if (a_data !== 32'h1234_5678) $display("FAIL drain_recapture_data: got %h want 12345678", a_data); else pass_cnt++;
        chk_cnt++; if (a_pc !== 32'h0000_0100) $display("FAIL drain_recapture_pc: got %h want 00000100", a_pc); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            commit(NOP, 32'h0000_0204 + 32'(i * 4), 32'h99);
        end
        chk_cnt++; if (a_cnt !== 32'd3) $display("FAIL drain_cnt: got %0d want 3", a_cnt); else pass_cnt++;
        chk_cnt++; if (a_flag !== 1'b1) $display("FAIL drain_done_flag: got %0b want 1", a_flag); else pass_cnt++;
        // DONE: further commits, including an ebreak, change nothing.
        commit(EBREAK, 32'h0000_0300, 32'h5);
        commit(NOP, 32'h0000_0304, 32'h6);
        chk_cnt++; if (a_data !== 32'h1234_5678) $display("FAIL done_data: got %h want 12345678", a_data); else pass_cnt++;
        chk_cnt++; if (a_cnt !== 32'd3) $display("FAIL done_cnt: got %0d want 3", a_cnt); else pass_cnt++;
        chk_cnt++; if (a_flag !== 1'b1) $display("FAIL done_sticky: got %0b want 1", a_flag); else pass_cnt++;
    endtask

    task automatic test_drain_zero();
        do_reset();
        chk_cnt++; if (b_flag !== 1'b0) $display("FAIL d0_pre_flag: got %0b want 0", b_flag); else pass_cnt++;
        commit(EBREAK, 32'h0000_0040, 32'd1);
        chk_cnt++; if (b_flag !== 1'b1) $display("FAIL d0_flag: got %0b want 1", b_flag); else pass_cnt++;
        chk_cnt++; if (b_data !== 32'd1) $display("FAIL d0_data: got %h want 1", b_data); else pass_cnt++;
        chk_cnt++; if (b_pc !== 32'h0000_0040) $display("FAIL d0_pc: got %h want 00000040", b_pc); else pass_cnt++;
        chk_cnt++; if (b_cnt !== 32'd1) $display("FAIL d0_cnt: got %0d want 1", b_cnt); else pass_cnt++;
        chk_cnt++; if (b_busy !== 1'b0) $display("FAIL d0_busy: got %0b want 0", b_busy); else pass_cnt++;
        if (b_data == 32'd1) $display("verdict from zero-drain run: fail code (a0=1)");
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 1; k <= 19; k++) step();
        chk_cnt++; if (c_flag !== 1'b0) $display("FAIL to_early: got %0b want 0 after edge 19", c_flag); else pass_cnt++;
        step();
        chk_cnt++; if (c_flag !== 1'b1) $display("FAIL to_flag: got %0b want 1 after edge 20", c_flag); else pass_cnt++;
        chk_cnt++; if (c_data !== 32'd1) $display("FAIL to_data: got %h want 1", c_data); else pass_cnt++;
        chk_cnt++; if (c_pc !== 32'hFFFF_FFFF) $display("FAIL to_pc: got %h want ffffffff", c_pc); else pass_cnt++;
        chk_cnt++; if (c_cnt !== 32'd0) $display("FAIL to_cnt: got %0d want 0", c_cnt); else pass_cnt++;
        chk_cnt++; if (c_busy !== 1'b0) $display("FAIL to_busy: got %0b want 0", c_busy); else pass_cnt++;
        commit(EBREAK, 32'h0000_0500, 32'd0);
        chk_cnt++; if (c_data !== 32'd1) $display("FAIL to_frozen_data: got %h want 1", c_data); else pass_cnt++;
        // Watchdog disabled on dut_a: still running.
        chk_cnt++; if (a_flag !== 1'b0) $display("FAIL wdog_off_flag: got %0b want 0", a_flag); else pass_cnt++;
    endtask

    task automatic test_ebreak_wins();
        do_reset();
        for (int k = 1; k <= 19; k++) step();
        commit(EBREAK, 32'h8000_0040, 32'd0);
        chk_cnt++; if (c_flag !== 1'b0) $display("FAIL win_flag: got %0b want 0", c_flag); else pass_cnt++;
        chk_cnt++; if (c_pc !== 32'h8000_0040) $display("FAIL win_pc: got %h want 80000040", c_pc); else pass_cnt++;
        chk_cnt++; if (c_data !== 32'd0) $display("FAIL win_data: got %h want 0", c_data); else pass_cnt++;
        chk_cnt++; if (c_cnt !== 32'd1) $display("FAIL win_cnt: got %0d want 1", c_cnt); else pass_cnt++;
        for (int k = 1; k <= 3; k++) step();
        chk_cnt++; if (c_flag !== 1'b0) $display("FAIL win_drain_early: got %0b want 0", c_flag); else pass_cnt++;
        step();
        chk_cnt++; if (c_flag !== 1'b1) $display("FAIL win_drain_flag: got %0b want 1", c_flag); else pass_cnt++;
        chk_cnt++; if (c_data !== 32'd0) $display("FAIL win_final_data: got %h want 0", c_data); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        commit(EBREAK, 32'h0000_0300, 32'h7);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_cnt++; if (a_data !== 32'd0) $display("FAIL rdrain_data: got %h want 0", a_data); else pass_cnt++;
        chk_cnt++; if (a_pc !== 32'd0) $display("FAIL rdrain_pc: got %h want 0", a_pc); else pass_cnt++;
        chk_cnt++; if (a_cnt !== 32'd0) $display("FAIL rdrain_cnt: got %0d want 0", a_cnt); else pass_cnt++;
        chk_cnt++; if (a_busy !== 1'b1) $display("FAIL rdrain_busy: got %0b want 1", a_busy); else pass_cnt++;
        // Two more edges would have finished the old drain; must stay clear.
        step();
        step();
        chk_cnt++; if (a_flag !== 1'b0) $display("FAIL rdrain_flag: got %0b want 0", a_flag); else pass_cnt++;

        commit(EBREAK, 32'h0000_0310, 32'h9);
        for (int k = 1; k <= 4; k++) step();
        chk_cnt++; if (a_flag !== 1'b1) $display("FAIL rdone_pre_flag: got %0b want 1", a_flag); else pass_cnt++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_cnt++; if (a_flag !== 1'b0) $display("FAIL rdone_flag: got %0b want 0", a_flag); else pass_cnt++;
        chk_cnt++; if (a_data !== 32'd0) $display("FAIL rdone_data: got %h want 0", a_data); else pass_cnt++;
        chk_cnt++; if (a_pc !== 32'd0) $display("FAIL rdone_pc: got %h want 0", a_pc); else pass_cnt++;
        chk_cnt++; if (a_cnt !== 32'd0) $display("FAIL rdone_cnt: got %0d want 0", a_cnt); else pass_cnt++;
        chk_cnt++; if (a_busy !== 1'b1) $display("FAIL rdone_busy: got %0b want 1", a_busy); else pass_cnt++;

        commit(EBREAK, 32'h0000_0400, 32'h55);
        for (int k = 1; k <= 3; k++) step();
        chk_cnt++; if (a_flag !== 1'b0) $display("FAIL fresh_early: got %0b want 0", a_flag); else pass_cnt++;
        step();
        chk_cnt++; if (a_flag !== 1'b1) $display("FAIL fresh_flag: got %0b want 1", a_flag); else pass_cnt++;
        chk_cnt++; if (a_data !== 32'h55) $display("FAIL fresh_data: got %h want 55", a_data); else pass_cnt++;
        chk_cnt++; if (a_cnt !== 32'd1) $display("FAIL fresh_cnt: got %0d want 1", a_cnt); else pass_cnt++;
    endtask

    initial begin
        rst       = 1'b1;
        cmt_valid = 1'b0;
        cmt_inst  = NOP;
        cmt_pc    = 32'd0;
        cmt_a0    = 32'd0;
        test_reset();
        test_ebreak_drain();
        test_drain_ignore();
        test_drain_zero();
        test_timeout();
        test_ebreak_wins();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL time_limit: simulation still running at %0t, want finished", $time);
        $fatal(1, "time limit");
    end

endmodule
